// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel 3x3 window generator.
package sobel_pkg;

    localparam int unsigned PIXEL_W   = 8;
    localparam int unsigned MAX_WIDTH = 1024;
    localparam int unsigned ADDR_W    = $clog2(MAX_WIDTH);
    localparam int unsigned ROW_W     = 16;

    typedef logic [PIXEL_W-1:0] pixel_t;
    typedef logic [ADDR_W-1:0]  col_t;
    typedef logic [ROW_W-1:0]   row_t;

    // Byte lane of p0..p7: p0..p3 go to window A, p4..p7 to window B; lane 3 is bits 31:24.
    localparam int unsigned P_LANE [8] = '{3, 2, 1, 0, 3, 2, 1, 0};

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } window_t;

    // Pack the eight neighbours (p[0] = top-left ... p[7] = bottom-right) into the CI operands.
    function automatic window_t pack_window(input pixel_t [7:0] p);
        window_t w;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            w.a[P_LANE[i]*PIXEL_W +: PIXEL_W]   = p[i];
            w.b[P_LANE[i+4]*PIXEL_W +: PIXEL_W] = p[i+4];
        end
        return w;
    endfunction

endpackage

// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out handshake bundle of the Sobel window generator.
interface sobel_window_gen_if;
    import sobel_pkg::*;

    logic        frame_start;
    logic        pixel_valid;
    pixel_t      pixel_in;
    logic        pixel_ready;
    logic        window_valid;
    logic        window_ready;
    logic [31:0] window_a;
    logic [31:0] window_b;
    col_t        window_x;
    row_t        window_y;

    // Pixel source / window consumer side.
    modport master (
        output frame_start, pixel_valid, pixel_in, window_ready,
        input  pixel_ready, window_valid, window_a, window_b, window_x, window_y
    );

    // Window generator side.
    modport slave (
        input  frame_start, pixel_valid, pixel_in, window_ready,
        output pixel_ready, window_valid, window_a, window_b, window_x, window_y
    );

endinterface

// File: rtl/sobel_line_buffer.sv
// One-line pixel store: one write port, one registered read port, no reset on contents.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int unsigned Depth = 640,
    localparam int unsigned AW   = $clog2(Depth)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  pixel_t        wr_data,
    input  logic [AW-1:0] rd_addr,
    output pixel_t        rd_data
);

    pixel_t mem [Depth];

    // Write the accepted column.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read every cycle; the address is held steady during a stall so the data stays valid.
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 neighbourhood generator feeding the Sobel custom instruction.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int unsigned ImageWidth = 640
) (
    input logic               clk,
    input logic               rst,
    sobel_window_gen_if.slave bus
);

    localparam int unsigned XW = $clog2(ImageWidth);
    typedef logic [XW-1:0] x_t;
    localparam x_t X_LAST = x_t'(ImageWidth - 1);

    x_t      x_q, x_d, cur_x, next_x, rd_addr;
    row_t    y_q, y_d, cur_y, next_y;
    logic    accept, emit;
    pixel_t  buf0_rd, buf1_rd;
    window_t win_new;
    pixel_t [7:0] px;

    // Two stored columns per row ([0] = left, [1] = centre); the right column is the live
    // incoming data (line buffer reads plus pixel_in), so the window is complete at accept.
    pixel_t [1:0] top_q, mid_q, bot_q;

    logic    win_valid_q;
    window_t win_q;
    col_t    win_x_q;
    row_t    win_y_q;

    // Handshake, effective coordinates and counter next-state.
    always_comb begin
        accept  = bus.pixel_valid & bus.pixel_ready;
        cur_x   = bus.frame_start ? '0 : x_q;
        cur_y   = bus.frame_start ? '0 : y_q;
        next_x  = (cur_x == X_LAST) ? '0 : cur_x + x_t'(1);
        next_y  = cur_y;
        if (cur_x == X_LAST && cur_y != '1) begin
            next_y = cur_y + row_t'(1);
        end
        x_d     = accept ? next_x : x_q;
        y_d     = accept ? next_y : y_q;
        // Prefetch the column of the next accept; never equals the column being written.
        rd_addr = x_d;
        emit    = accept && (cur_x >= x_t'(2)) && (cur_y >= row_t'(2));
    end

    // Assemble the shifted window and pack it into the CI operand layout.
    always_comb begin
        px[0]   = top_q[0];
        px[1]   = top_q[1];
        px[2]   = buf1_rd;
        px[3]   = mid_q[0];
        px[4]   = buf0_rd;
        px[5]   = bot_q[0];
        px[6]   = bot_q[1];
        px[7]   = bus.pixel_in;
        win_new = pack_window(px);
    end

    // Column / row counters advance only on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    // Column shift register moves left on every accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_q <= '0;
            mid_q <= '0;
            bot_q <= '0;
        end else if (accept) begin
            top_q <= {buf1_rd, top_q[1]};
            mid_q <= {buf0_rd, mid_q[1]};
            bot_q <= {bus.pixel_in, bot_q[1]};
        end
    end

    // One-deep output register: load wins over take, contents held while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_valid_q <= 1'b0;
            win_q       <= '0;
            win_x_q     <= '0;
            win_y_q     <= '0;
        end else if (emit) begin
            win_valid_q <= 1'b1;
            win_q       <= win_new;
            win_x_q     <= col_t'(cur_x - x_t'(1));
            win_y_q     <= cur_y - row_t'(1);
        end else if (bus.window_ready) begin
            win_valid_q <= 1'b0;
        end
    end

    // buf0 holds row y-1, buf1 holds row y-2 (fed from buf0's old contents).
    sobel_line_buffer #(
        .Depth (ImageWidth)
    ) u_buf0 (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (cur_x),
        .wr_data (bus.pixel_in),
        .rd_addr (rd_addr),
        .rd_data (buf0_rd)
    );

    sobel_line_buffer #(
        .Depth (ImageWidth)
    ) u_buf1 (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (cur_x),
        .wr_data (buf0_rd),
        .rd_addr (rd_addr),
        .rd_data (buf1_rd)
    );

    assign bus.pixel_ready  = !win_valid_q | bus.window_ready;
    assign bus.window_valid = win_valid_q;
    assign bus.window_a     = win_q.a;
    assign bus.window_b     = win_q.b;
    assign bus.window_x     = win_x_q;
    assign bus.window_y     = win_y_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Randomised self-checking bench for sobel_window_gen against an image-level reference model.
module tb_sobel_window_gen;
    import sobel_pkg::*;

    localparam int unsigned W = 4;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [9:0]  x;
        logic [15:0] y;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sobel_window_gen_if bus();

    sobel_window_gen #(
        .ImageWidth (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model state: whole image indexed by (row, column).
    logic [7:0] img [0:63][0:W-1];
    int   mx, my;
    exp_t exp_q[$];
    int   n_expected;
    bit   occupied;
    bit   hold_pending;
    exp_t hold_snap;

    // Observed DUT windows and the cycle they were taken.
    exp_t obs_q[$];
    int   obs_cyc[$];
    int   cyc;
    int   n_ready_low;

    int   stall_left;
    int   ready_pct;
    int   gap_pct;

    // Basic 4x4 ramp frame expectations, windows in raster order.
    logic [31:0] basic_a [4] = '{32'h00010210, 32'h01020311, 32'h10111220, 32'h11121321};
    logic [31:0] basic_b [4] = '{32'h12202122, 32'h13212223, 32'h22303132, 32'h23313233};
    int          basic_x [4] = '{1, 2, 1, 2};
    int          basic_y [4] = '{1, 1, 2, 2};

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t dut_window();
        exp_t w;
        w.a = bus.window_a;
        w.b = bus.window_b;
        w.x = bus.window_x;
        w.y = bus.window_y;
        return w;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        occupied     = 0;
        hold_pending = 0;
        mx           = 0;
        my           = 0;
    endtask

    task automatic model_accept(input bit fs, input logic [7:0] pix, output bit loaded);
        int   cx, cy;
        exp_t e;
        cx     = fs ? 0 : mx;
        cy     = fs ? 0 : my;
        loaded = 0;
        if (cy < 64) img[cy][cx] = pix;
        if (cx >= 2 && cy >= 2 && cy < 64) begin
            e.a = {img[cy-2][cx-2], img[cy-2][cx-1], img[cy-2][cx], img[cy-1][cx-2]};
            e.b = {img[cy-1][cx], img[cy][cx-2], img[cy][cx-1], img[cy][cx]};
            e.x = 10'(cx - 1);
            e.y = 16'(cy - 1);
            exp_q.push_back(e);
            n_expected++;
            loaded = 1;
        end
        if (cx == W - 1) begin
            mx = 0;
            my = (cy < 65535) ? cy + 1 : cy;
        end else begin
            mx = cx + 1;
            my = cy;
        end
    endtask

    // One clock: drive at the falling edge, check 1 time unit later, update the model.
    task automatic cycle(input bit fs, input bit pv, input logic [7:0] pix, output bit accepted);
        bit   wr, take, loaded;
        exp_t got;
        @(negedge clk);
        if (stall_left > 0 && occupied) begin
            wr = 0;
            stall_left--;
        end else begin
            wr = ($urandom_range(99) < ready_pct);
        end
        bus.frame_start  = fs;
        bus.pixel_valid  = pv;
        bus.pixel_in     = pix;
        bus.window_ready = wr;
        #1;
        cyc++;
        got = dut_window();
        if (!bus.pixel_ready) n_ready_low++;
        check_eq("window_valid", 96'(bus.window_valid), 96'(occupied));
        check_eq("pixel_ready", 96'(bus.pixel_ready), 96'(!occupied || wr));
        if (hold_pending) check_eq("held_window", got, hold_snap);
        if (bus.window_valid && wr) begin
            obs_q.push_back(got);
            obs_cyc.push_back(cyc);
        end
        take = occupied && wr;
        if (take) check_eq("window", got, exp_q.pop_front());
        accepted = pv && (!occupied || wr);
        loaded   = 0;
        if (accepted) model_accept(fs, pix, loaded);
        hold_pending = occupied && !wr;
        hold_snap    = got;
        if (loaded) occupied = 1;
        else if (take) occupied = 0;
    endtask

    task automatic send_pixel(input bit fs, input logic [7:0] pix);
        bit acc;
        bit dummy;
        int tries;
        tries = 0;
        while (gap_pct > 0 && $urandom_range(99) < gap_pct && tries < 4) begin
            cycle(0, 0, 8'($urandom), dummy);
            tries++;
        end
        tries = 0;
        do begin
            cycle(fs, 1, pix, acc);
            tries++;
        end while (!acc && tries < 64);
        if (!acc) check_eq("accept_timeout", 96'(acc), 96'(1));
    endtask

    task automatic idle(input int n);
        bit dummy;
        for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, dummy);
    endtask

    // Rows [0, rows) of a frame; last_row_cols limits the final row.
    task automatic send_frame(input int rows, input int last_row_cols, input bit ramp,
                              input bit rand_fs);
        bit fs;
        int ncols;
        for (int yy = 0; yy < rows; yy++) begin
            ncols = (yy == rows - 1) ? last_row_cols : W;
            for (int xx = 0; xx < ncols; xx++) begin
                fs = (xx == 0 && yy == 0);
                if (rand_fs && $urandom_range(99) < 3) fs = 1;
                send_pixel(fs, ramp ? 8'(16 * yy + xx) : 8'($urandom));
            end
        end
    endtask

    task automatic clear_obs();
        obs_q.delete();
        obs_cyc.delete();
        n_ready_low = 0;
    endtask

    task automatic check_basic(input string tag);
        check_eq({tag, "_count"}, 96'(obs_q.size()), 96'(4));
        if (obs_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check_eq($sformatf("%s_a%0d", tag, i), 96'(obs_q[i].a), 96'(basic_a[i]));
                check_eq($sformatf("%s_b%0d", tag, i), 96'(obs_q[i].b), 96'(basic_b[i]));
                check_eq($sformatf("%s_x%0d", tag, i), 96'(obs_q[i].x), 96'(basic_x[i]));
                check_eq($sformatf("%s_y%0d", tag, i), 96'(obs_q[i].y), 96'(basic_y[i]));
            end
        end
    endtask

    initial begin
        bit dummy;
        rst              = 1'b1;
        bus.frame_start  = 1'b0;
        bus.pixel_valid  = 1'b0;
        bus.pixel_in     = '0;
        bus.window_ready = 1'b0;
        cyc = 0; n_expected = 0; stall_left = 0; ready_pct = 100; gap_pct = 0;
        model_reset();
        clear_obs();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_window_valid", 96'(bus.window_valid), 96'(0));
        check_eq("rst_window_a", 96'(bus.window_a), 96'(0));
        check_eq("rst_window_b", 96'(bus.window_b), 96'(0));
        check_eq("rst_window_x", 96'(bus.window_x), 96'(0));
        check_eq("rst_window_y", 96'(bus.window_y), 96'(0));
        check_eq("rst_pixel_ready", 96'(bus.pixel_ready), 96'(1));
        @(negedge clk);
        rst = 1'b0;

        // Basic frame, continuous stream.
        send_frame(4, W, 1, 0);
        idle(3);
        check_basic("basic");
        if (obs_cyc.size() >= 2) check_eq("back_to_back", 96'(obs_cyc[1] - obs_cyc[0]), 96'(1));

        // Backpressure: five stalled cycles once the first window is up.
        clear_obs();
        stall_left = 5;
        send_frame(4, W, 1, 0);
        idle(3);
        check_basic("bp");
        check_eq("bp_ready_low", 96'(n_ready_low), 96'(5));

        // Restart mid-frame while a window is pending; it must still drain.
        clear_obs();
        send_frame(3, 3, 1, 0);
        stall_left = 2;
        send_frame(4, W, 1, 0);
        idle(3);
        check_eq("restart_count", 96'(obs_q.size()), 96'(5));
        if (obs_q.size() == 5) begin
            check_eq("restart_old_a", 96'(obs_q[0].a), 96'(basic_a[0]));
            check_eq("restart_new_x", 96'(obs_q[1].x), 96'(1));
            check_eq("restart_new_y", 96'(obs_q[1].y), 96'(1));
            check_eq("restart_new_b", 96'(obs_q[1].b), 96'(basic_b[0]));
        end

        // Reset while a window is pending, then a clean frame.
        send_frame(3, W, 1, 0);
        ready_pct = 0;
        idle(1);
        check_eq("pre_rst_valid", 96'(bus.window_valid), 96'(1));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midrst_valid", 96'(bus.window_valid), 96'(0));
        check_eq("midrst_a", 96'(bus.window_a), 96'(0));
        check_eq("midrst_b", 96'(bus.window_b), 96'(0));
        model_reset();
        @(negedge clk);
        rst       = 1'b0;
        ready_pct = 100;
        clear_obs();
        send_frame(4, W, 1, 0);
        idle(3);
        check_basic("post_rst");

        // Random frames, random backpressure, gaps and occasional restarts.
        clear_obs();
        n_expected = 0;
        ready_pct  = 60;
        gap_pct    = 25;
        for (int f = 0; f < 12; f++) begin
            send_frame(3 + $urandom_range(3), W, 0, 1);
        end
        ready_pct = 100;
        gap_pct   = 0;
        idle(4);
        check_eq("random_window_count", 96'(obs_q.size()), 96'(n_expected));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    // Hard stop so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched + 1);
        $fatal(1, "timeout");
    end

endmodule
